alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Execute stage of the single-cycle MIPS core: ALU-control decode (ALUOp+func -> ALUCtr),
//  32-bit ALU, and branch-condition logic (BEQ/BNE/BGTZ AND/OR network).
//  Result, flags and branch are combinational for same-cycle use. A status register
//  holds the last cycle's flags for debug and bench observation.
// PARAMETERS
//  (none) -- data width fixed at 32, shamt width fixed at 5.
// PORTS
//  clk        in   1   clock; status register samples on rising edge
//  rstb       in   1   asynchronous, active-low reset
//  ALUOp      in   3   op class from control unit
//  func       in   6   R-type function field
//  a          in   32  operand A (busA)
//  b          in   32  operand B (busB or sign-extended imm16)
//  shamt      in   5   shift amount for SLL/SRL/SRA
//  BranchEQ   in   1   beq instruction
//  BranchNE   in   1   bne instruction
//  BranchGTZ  in   1   bgtz instruction
//  ALUCtr     out  4   decoded ALU control (exported for debug)
//  result     out  32  ALU result
//  carry_out  out  1   carry out of bit 31 (ADD/ADDU); no-borrow, a>=b unsigned (SUB/SUBU); else 0
//  overflow   out  1   signed overflow, ADD/SUB only; 0 for all other ops
//  zero       out  1   result == 0
//  branch     out  1   branch taken
//  flags_q    out  4   registered {zero, result[31], carry_out, overflow}
//  branch_q   out  1   registered branch
// BEHAVIOUR
//  ALUOp: 000 ADD (lw/sw/addi), 001 SUB (beq/bne/bgtz), 010 R-type (use func), 011 AND (andi),
//   100 OR (ori), 101 SLT (slti), 110 LUI, 111 XOR (xori).
//  func (ALUOp=010): 20 ADD, 21 ADDU, 22 SUB, 23 SUBU, 24 AND, 25 OR, 26 XOR, 27 NOR,
//   2A SLT, 2B SLTU, 00 SLL, 02 SRL, 03 SRA (hex). Any other func -> ADD.
//  ALUCtr: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT, 5 NOR, 6 XOR, 7 SLL, 8 SRL, 9 SRA, A SLTU,
//   B LUI, C ADDU, D SUBU; E/F unused, produce result 0 and all flags 0.
//  Shifts operate on b by shamt; SRA replicates b[31]. LUI: {b[15:0],16'h0}.
//  SLT signed compare, SLTU unsigned; result is 32'h1 or 32'h0.
//  Subtraction = a + ~b + 1; one shared 33-bit adder for ADD/ADDU/SUB/SUBU/SLT/SLTU.
//  overflow: ADD -> a[31]==b[31] && r[31]!=a[31]; SUB -> a[31]!=b[31] && r[31]!=a[31].
//  branch = (BranchEQ & zero) | (BranchNE & ~zero) | (BranchGTZ & ~result[31] & ~zero).
//  Multiple Branch* asserted: OR of all terms. BGTZ relies on control issuing SUB with b=0.
//  Combinational outputs: zero latency from any input change.
//  flags_q/branch_q: 1-cycle latency, update every rising clk, no enable.
//  rstb low (any time, async): flags_q=4'b0, branch_q=0 immediately; combinational
//   outputs unaffected by reset. Registers resume sampling on first edge after rstb rises.
// STRUCTURE
//  Package alu_exec_pkg: ALUOp codes, func codes, ALUCtr codes as localparams.
//  Sub-module alu_exec_decode: pure combinational ALUOp/func -> ALUCtr.
//  Top: datapath case on ALUCtr, branch gates, status register.
// TESTING
//  ALUOp=010, func=20, a=7FFFFFFF, b=1 -> result 80000000, overflow 1, carry 0, ALUCtr 2.
//  ALUOp=001, a=5, b=5, BranchEQ=1 -> result 0, zero 1, carry 1, branch 1; BranchNE=1 alone -> branch 0.
//  ALUOp=001, a=3, b=0, BranchGTZ=1 -> branch 1; a=FFFFFFFF -> branch 0; a=0 -> branch 0.
//  ALUOp=010, func=03, b=80000000, shamt=4 -> F8000000; func=02 -> 08000000; func=2A a=FFFFFFFF b=1 -> 1; func=2B -> 0.
//  ALUOp=110, b=0000ABCD -> ABCD0000; ALUOp=010 func=3F a=2 b=3 -> 5 (default ADD).
//  Drive zero-result op, clock edge -> flags_q[3]=1, branch_q tracks; pull rstb low mid-cycle -> flags_q=0 before next edge.

Source files
------------

// File: rtl/alu_exec_pkg.sv
// Shared encodings for the MIPS execute stage: ALUOp classes, R-type func codes
// and the internal ALU control codes.
package alu_exec_pkg;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_RTYPE = 3'b010;
  localparam logic [2:0] OP_AND   = 3'b011;
  localparam logic [2:0] OP_OR    = 3'b100;
  localparam logic [2:0] OP_SLT   = 3'b101;
  localparam logic [2:0] OP_LUI   = 3'b110;
  localparam logic [2:0] OP_XOR   = 3'b111;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [3:0] CTR_AND  = 4'h0;
  localparam logic [3:0] CTR_OR   = 4'h1;
  localparam logic [3:0] CTR_ADD  = 4'h2;
  localparam logic [3:0] CTR_SUB  = 4'h3;
  localparam logic [3:0] CTR_SLT  = 4'h4;
  localparam logic [3:0] CTR_NOR  = 4'h5;
  localparam logic [3:0] CTR_XOR  = 4'h6;
  localparam logic [3:0] CTR_SLL  = 4'h7;
  localparam logic [3:0] CTR_SRL  = 4'h8;
  localparam logic [3:0] CTR_SRA  = 4'h9;
  localparam logic [3:0] CTR_SLTU = 4'hA;
  localparam logic [3:0] CTR_LUI  = 4'hB;
  localparam logic [3:0] CTR_ADDU = 4'hC;
  localparam logic [3:0] CTR_SUBU = 4'hD;

  // Ops that feed the shared adder with ~b and a carry-in of 1.
  function automatic logic is_subtract(input logic [3:0] ctr);
    return (ctr == CTR_SUB) || (ctr == CTR_SUBU) ||
           (ctr == CTR_SLT) || (ctr == CTR_SLTU);
  endfunction

endpackage

// File: rtl/alu_exec_decode.sv
// ALU control decode: maps the control unit's op class plus the R-type func
// field onto a single ALU control code.
module alu_exec_decode
  import alu_exec_pkg::*;
(
  input  logic [2:0] ALUOp,
  input  logic [5:0] func,
  output logic [3:0] ALUCtr
);

  logic [3:0] rtype_ctr;

  // Unknown func codes fall back to ADD so a bad encoding never yields garbage.
  always_comb begin
    rtype_ctr = CTR_ADD;
    case (func)
      FN_ADD:  rtype_ctr = CTR_ADD;
      FN_ADDU: rtype_ctr = CTR_ADDU;
      FN_SUB:  rtype_ctr = CTR_SUB;
      FN_SUBU: rtype_ctr = CTR_SUBU;
      FN_AND:  rtype_ctr = CTR_AND;
      FN_OR:   rtype_ctr = CTR_OR;
      FN_XOR:  rtype_ctr = CTR_XOR;
      FN_NOR:  rtype_ctr = CTR_NOR;
      FN_SLT:  rtype_ctr = CTR_SLT;
      FN_SLTU: rtype_ctr = CTR_SLTU;
      FN_SLL:  rtype_ctr = CTR_SLL;
      FN_SRL:  rtype_ctr = CTR_SRL;
      FN_SRA:  rtype_ctr = CTR_SRA;
      default: rtype_ctr = CTR_ADD;
    endcase
  end

  always_comb begin
    ALUCtr = CTR_ADD;
    case (ALUOp)
      OP_ADD:   ALUCtr = CTR_ADD;
      OP_SUB:   ALUCtr = CTR_SUB;
      OP_RTYPE: ALUCtr = rtype_ctr;
      OP_AND:   ALUCtr = CTR_AND;
      OP_OR:    ALUCtr = CTR_OR;
      OP_SLT:   ALUCtr = CTR_SLT;
      OP_LUI:   ALUCtr = CTR_LUI;
      OP_XOR:   ALUCtr = CTR_XOR;
      default:  ALUCtr = CTR_ADD;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage of the single-cycle MIPS core: ALU control decode, 32-bit ALU,
// branch-condition network and a debug status register of last cycle's flags.
module alu_exec_unit
  import alu_exec_pkg::*;
(
  input  logic        clk,
  input  logic        rstb,
  input  logic [2:0]  ALUOp,
  input  logic [5:0]  func,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  shamt,
  input  logic        BranchEQ,
  input  logic        BranchNE,
  input  logic        BranchGTZ,
  output logic [3:0]  ALUCtr,
  output logic [31:0] result,
  output logic        carry_out,
  output logic        overflow,
  output logic        zero,
  output logic        branch,
  output logic [3:0]  flags_q,
  output logic        branch_q
);

  logic        sub_op;
  logic [31:0] b_eff;
  logic [32:0] sum;
  logic        add_ovf;
  logic        sub_ovf;
  logic        valid_ctr;

  alu_exec_decode u_decode (
    .ALUOp  (ALUOp),
    .func   (func),
    .ALUCtr (ALUCtr)
  );

  // One 33-bit adder serves add, subtract and both compares; bit 32 is the carry.
  assign sub_op  = is_subtract(ALUCtr);
  assign b_eff   = sub_op ? ~b : b;
  assign sum     = {1'b0, a} + {1'b0, b_eff} + {32'b0, sub_op};
  assign add_ovf = (a[31] == b[31]) && (sum[31] != a[31]);
  assign sub_ovf = (a[31] != b[31]) && (sum[31] != a[31]);

  always_comb begin
    result    = '0;
    carry_out = 1'b0;
    overflow  = 1'b0;
    valid_ctr = 1'b1;
    case (ALUCtr)
      CTR_AND:  result = a & b;
      CTR_OR:   result = a | b;
      CTR_NOR:  result = ~(a | b);
      CTR_XOR:  result = a ^ b;
      CTR_ADD: begin
        result    = sum[31:0];
        carry_out = sum[32];
        overflow  = add_ovf;
      end
      CTR_ADDU: begin
        result    = sum[31:0];
        carry_out = sum[32];
      end
      CTR_SUB: begin
        result    = sum[31:0];
        carry_out = sum[32];
        overflow  = sub_ovf;
      end
      CTR_SUBU: begin
        result    = sum[31:0];
        carry_out = sum[32];
      end
      // Signed less-than is the sign of a-b corrected by its overflow.
      CTR_SLT:  result = {31'b0, sum[31] ^ sub_ovf};
      CTR_SLTU: result = {31'b0, ~sum[32]};
      CTR_SLL:  result = b << shamt;
      CTR_SRL:  result = b >> shamt;
      CTR_SRA:  result = $unsigned($signed(b) >>> shamt);
      CTR_LUI:  result = {b[15:0], 16'h0000};
      default:  valid_ctr = 1'b0;
    endcase
  end

  assign zero   = valid_ctr && (result == 32'h0);
  assign branch = (BranchEQ & zero) | (BranchNE & ~zero) |
                  (BranchGTZ & ~result[31] & ~zero);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      flags_q  <= 4'b0000;
      branch_q <= 1'b0;
    end else begin
      flags_q  <= {zero, result[31], carry_out, overflow};
      branch_q <= branch;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit: ALU ops, flags, branch
// network and the asynchronously reset status register.
module tb_alu_exec_unit;

  logic        clk;
  logic        rstb;
  logic [2:0]  ALUOp;
  logic [5:0]  func;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  shamt;
  logic        BranchEQ;
  logic        BranchNE;
  logic        BranchGTZ;
  logic [3:0]  ALUCtr;
  logic [31:0] result;
  logic        carry_out;
  logic        overflow;
  logic        zero;
  logic        branch;
  logic [3:0]  flags_q;
  logic        branch_q;

  int vectors;
  int miscompares;

  alu_exec_unit dut (
    .clk       (clk),
    .rstb      (rstb),
    .ALUOp     (ALUOp),
    .func      (func),
    .a         (a),
    .b         (b),
    .shamt     (shamt),
    .BranchEQ  (BranchEQ),
    .BranchNE  (BranchNE),
    .BranchGTZ (BranchGTZ),
    .ALUCtr    (ALUCtr),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero),
    .branch    (branch),
    .flags_q   (flags_q),
    .branch_q  (branch_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // br is {BranchEQ, BranchNE, BranchGTZ}.
  task automatic applyStimulus(input logic [2:0] op, input logic [5:0] fn,
                               input logic [31:0] av, input logic [31:0] bv,
                               input logic [4:0] sh, input logic [2:0] br);
    ALUOp     = op;
    func      = fn;
    a         = av;
    b         = bv;
    shamt     = sh;
    BranchEQ  = br[2];
    BranchNE  = br[1];
    BranchGTZ = br[0];
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rstb        = 1'b1;
    applyStimulus(3'b000, 6'h00, 32'h0, 32'h0, 5'd0, 3'b000);
    #1;
    rstb = 1'b0;
    #1;
    $display("[TB] reset asserted");
    checkOutput("rst_flags_q", {28'b0, flags_q}, 32'h0);
    checkOutput("rst_branch_q", {31'b0, branch_q}, 32'h0);

    // Signed add overflow
    applyStimulus(3'b010, 6'h20, 32'h7FFFFFFF, 32'h1, 5'd0, 3'b000);
    checkOutput("add_res", result, 32'h80000000);
    checkOutput("add_ovf", {31'b0, overflow}, 32'h1);
    checkOutput("add_cy", {31'b0, carry_out}, 32'h0);
    checkOutput("add_ctr", {28'b0, ALUCtr}, 32'h2);

    // ADDU: same sum, no overflow reported
    applyStimulus(3'b010, 6'h21, 32'h7FFFFFFF, 32'h1, 5'd0, 3'b000);
    checkOutput("addu_res", result, 32'h80000000);
    checkOutput("addu_ovf", {31'b0, overflow}, 32'h0);
    checkOutput("addu_ctr", {28'b0, ALUCtr}, 32'hC);

    // lw/sw class add with carry out and zero result
    applyStimulus(3'b000, 6'h00, 32'hFFFFFFFF, 32'h1, 5'd0, 3'b000);
    checkOutput("addi_res", result, 32'h0);
    checkOutput("addi_cy", {31'b0, carry_out}, 32'h1);
    checkOutput("addi_zero", {31'b0, zero}, 32'h1);
    checkOutput("addi_ovf", {31'b0, overflow}, 32'h0);

    // BEQ / BNE
    applyStimulus(3'b001, 6'h00, 32'h5, 32'h5, 5'd0, 3'b100);
    checkOutput("beq_res", result, 32'h0);
    checkOutput("beq_zero", {31'b0, zero}, 32'h1);
    checkOutput("beq_cy", {31'b0, carry_out}, 32'h1);
    checkOutput("beq_br", {31'b0, branch}, 32'h1);
    applyStimulus(3'b001, 6'h00, 32'h5, 32'h5, 5'd0, 3'b010);
    checkOutput("bne_eq_br", {31'b0, branch}, 32'h0);
    applyStimulus(3'b001, 6'h00, 32'h5, 32'h4, 5'd0, 3'b010);
    checkOutput("bne_ne_br", {31'b0, branch}, 32'h1);

    // BGTZ with b=0
    applyStimulus(3'b001, 6'h00, 32'h3, 32'h0, 5'd0, 3'b001);
    checkOutput("bgtz_pos_br", {31'b0, branch}, 32'h1);
    applyStimulus(3'b001, 6'h00, 32'hFFFFFFFF, 32'h0, 5'd0, 3'b001);
    checkOutput("bgtz_neg_br", {31'b0, branch}, 32'h0);
    applyStimulus(3'b001, 6'h00, 32'h0, 32'h0, 5'd0, 3'b001);
    checkOutput("bgtz_zero_br", {31'b0, branch}, 32'h0);

    // SUB overflow and SUBU borrow
    applyStimulus(3'b010, 6'h22, 32'h80000000, 32'h1, 5'd0, 3'b000);
    checkOutput("sub_res", result, 32'h7FFFFFFF);
    checkOutput("sub_ovf", {31'b0, overflow}, 32'h1);
    checkOutput("sub_cy", {31'b0, carry_out}, 32'h1);
    applyStimulus(3'b010, 6'h23, 32'h1, 32'h2, 5'd0, 3'b000);
    checkOutput("subu_res", result, 32'hFFFFFFFF);
    checkOutput("subu_cy", {31'b0, carry_out}, 32'h0);
    checkOutput("subu_ovf", {31'b0, overflow}, 32'h0);

    // Shifts
    applyStimulus(3'b010, 6'h03, 32'h0, 32'h80000000, 5'd4, 3'b000);
    checkOutput("sra_res", result, 32'hF8000000);
    applyStimulus(3'b010, 6'h02, 32'h0, 32'h80000000, 5'd4, 3'b000);
    checkOutput("srl_res", result, 32'h08000000);
    applyStimulus(3'b010, 6'h00, 32'h0, 32'h1, 5'd31, 3'b000);
    checkOutput("sll_res", result, 32'h80000000);

    // Compares
    applyStimulus(3'b010, 6'h2A, 32'hFFFFFFFF, 32'h1, 5'd0, 3'b000);
    checkOutput("slt_res", result, 32'h1);
    checkOutput("slt_cy", {31'b0, carry_out}, 32'h0);
    applyStimulus(3'b010, 6'h2B, 32'hFFFFFFFF, 32'h1, 5'd0, 3'b000);
    checkOutput("sltu_res", result, 32'h0);
    checkOutput("sltu_ctr", {28'b0, ALUCtr}, 32'hA);
    applyStimulus(3'b101, 6'h00, 32'hFFFFFFFB, 32'h3, 5'd0, 3'b000);
    checkOutput("slti_res", result, 32'h1);

    // Logic ops
    applyStimulus(3'b011, 6'h00, 32'h0000F0F0, 32'h0000FF00, 5'd0, 3'b000);
    checkOutput("andi_res", result, 32'h0000F000);
    applyStimulus(3'b100, 6'h00, 32'h0000F0F0, 32'h0000FF00, 5'd0, 3'b000);
    checkOutput("ori_res", result, 32'h0000FFF0);
    applyStimulus(3'b111, 6'h00, 32'h0000F0F0, 32'h0000FF00, 5'd0, 3'b000);
    checkOutput("xori_res", result, 32'h00000FF0);
    applyStimulus(3'b010, 6'h27, 32'h0, 32'h0, 5'd0, 3'b000);
    checkOutput("nor_res", result, 32'hFFFFFFFF);

    // LUI and default func
    applyStimulus(3'b110, 6'h00, 32'h0, 32'h0000ABCD, 5'd0, 3'b000);
    checkOutput("lui_res", result, 32'hABCD0000);
    checkOutput("lui_ctr", {28'b0, ALUCtr}, 32'hB);
    applyStimulus(3'b010, 6'h3F, 32'h2, 32'h3, 5'd0, 3'b000);
    checkOutput("dflt_res", result, 32'h5);
    checkOutput("dflt_ctr", {28'b0, ALUCtr}, 32'h2);

    // Status register: release reset, then sample a zero-result BEQ
    @(negedge clk);
    rstb = 1'b1;
    applyStimulus(3'b001, 6'h00, 32'h5, 32'h5, 5'd0, 3'b100);
    @(posedge clk);
    #1;
    checkOutput("reg_flags_beq", {28'b0, flags_q}, 32'hA);
    checkOutput("reg_br_beq", {31'b0, branch_q}, 32'h1);

    @(negedge clk);
    applyStimulus(3'b010, 6'h20, 32'h7FFFFFFF, 32'h1, 5'd0, 3'b010);
    @(posedge clk);
    #1;
    checkOutput("reg_flags_ovf", {28'b0, flags_q}, 32'h5);
    checkOutput("reg_br_bne", {31'b0, branch_q}, 32'h1);

    @(negedge clk);
    applyStimulus(3'b001, 6'h00, 32'h5, 32'h5, 5'd0, 3'b010);
    @(posedge clk);
    #1;
    checkOutput("reg_br_off", {31'b0, branch_q}, 32'h0);
    checkOutput("reg_flags_z", {28'b0, flags_q}, 32'hA);

    @(negedge clk);
    applyStimulus(3'b001, 6'h00, 32'h5, 32'h5, 5'd0, 3'b100);
    @(posedge clk);
    #1;
    checkOutput("reg_br_on", {31'b0, branch_q}, 32'h1);

    // Async reset mid-cycle clears before the next edge
    #2;
    rstb = 1'b0;
    #1;
    checkOutput("async_flags", {28'b0, flags_q}, 32'h0);
    checkOutput("async_br", {31'b0, branch_q}, 32'h0);
    checkOutput("async_comb_br", {31'b0, branch}, 32'h1);
    @(posedge clk);
    #1;
    checkOutput("held_flags", {28'b0, flags_q}, 32'h0);

    @(negedge clk);
    rstb = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("resume_flags", {28'b0, flags_q}, 32'hA);
    checkOutput("resume_br", {31'b0, branch_q}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
